// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and clear-FSM state encoding for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_mp_pkg;

  // Clear engine states (2-bit encoding)
  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/regfile_mp_rdport.sv
// regfile_rdport: one read port with zero/enable/bypass priority mux and optional output register.
// Latency: 0 cycles combinational, 1 cycle when REGFILE_RDREG_EN is defined.
// Backpressure: none; the output is forced to zero while the clear sweep is running.
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
`ifdef REGFILE_RDREG_EN
  input  logic              clk_i,
`endif
  input  logic              rst_n_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [DATA_W-1:0] entry_i,
  input  logic              busy_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] rdata_d;

  // Priority mux: zero conditions first, then port-1 bypass, port-0 bypass, stored entry
  always_comb begin
    rdata_d = '0;
    if (!rst_n_i || busy_i || (re_i != READ_ENABLE) || (raddr_i == '0)) begin
      rdata_d = '0;
    end else if ((we1_i == WRITE_ENABLE) && (waddr1_i == raddr_i)) begin
      rdata_d = wdata1_i;
    end else if ((we0_i == WRITE_ENABLE) && (waddr0_i == raddr_i)) begin
      rdata_d = wdata0_i;
    end else begin
      rdata_d = entry_i;
    end
  end

`ifdef REGFILE_RDREG_EN
  logic [DATA_W-1:0] rdata_q;

  // Output register: bypass is resolved before the flop so same-cycle writes are captured
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
`else
  assign rdata_o = rdata_d;
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, 2 prioritised write ports, NRD bypassed read ports, clear engine.
// Latency: reads 0 cycles (1 cycle with REGFILE_RDREG_EN defined); writes land at the next clk edge.
// Backpressure: writes are dropped while clr_busy is high; the pipeline is expected to stall on it.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              clr_busy_q;
  logic              clr_done_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr0_hit;
  logic wr1_hit;

  // Entry 0 is hard-wired to zero, so writes targeting it are simply never performed
  assign wr0_hit = (we0 == WRITE_ENABLE) && (waddr0 != '0) && !clr_busy_q;
  assign wr1_hit = (we1 == WRITE_ENABLE) && (waddr1 != '0) && !clr_busy_q;

  // Clear engine: sweep entries 1..DEPTH-1, stopping on the last address so the pointer never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLR_IDLE;
      ptr_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_req) begin
            state_q    <= CLR_SWEEP;
            ptr_q      <= ADDR_W'(1);
            clr_busy_q <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          if (ptr_q == LAST_ADDR) begin
            state_q    <= CLR_DONE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        CLR_DONE: begin
          state_q    <= CLR_IDLE;
          clr_done_q <= 1'b0;
        end
        default: begin
          state_q    <= CLR_IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep clears one entry per cycle, otherwise port 1 is applied after port 0 so it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == CLR_SWEEP) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (wr0_hit) begin
        mem_q[waddr0] <= wdata0;
      end
      if (wr1_hit) begin
        mem_q[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[k*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
`ifdef REGFILE_RDREG_EN
      .clk_i    (clk),
`endif
      .rst_n_i  (rst_n),
      .re_i     (re[k]),
      .raddr_i  (ra),
      .we0_i    (we0),
      .waddr0_i (waddr0),
      .wdata0_i (wdata0),
      .we1_i    (we1),
      .waddr1_i (waddr1),
      .wdata1_i (wdata1),
      .entry_i  (mem_q[ra]),
      .busy_i   (clr_busy_q),
      .rdata_o  (rdata[k*DATA_W +: DATA_W])
    );
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule
